stv_stride_sequencer: RTL and testbench
=======================================

# stv_stride_sequencer

Sequences a programmable strided address range through one or more passes, emitting one address per beat on a valid/ready stream. It accepts a job description through a config handshake, then counts with runtime min, max and step, with optional direction reversal ("bounce") between passes. It reports completion through a status pulse. It is the control front end that drives strided buffer and memory walks in the utility layer.

## Interface
Parameters:
- `WIDTH`, 8: address/counter width.
- `PASS_W`, 8: width of the pass-count field.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cfg_valid`  in  1  job descriptor valid.
- `cfg_ready`  out  1  sequencer idle; accepts a descriptor.
- `cfg_min`  in  WIDTH  lowest address (inclusive).
- `cfg_max`  in  WIDTH  highest address (inclusive).
- `cfg_step`  in  WIDTH  stride.
- `cfg_passes`  in  PASS_W  number of passes.
- `cfg_bounce`  in  1  0: every pass counts up from min; 1: passes alternate up (from min) and down (from max), starting up.
- `abort`  in  1  cancel the running job.
- `out_valid`  out  1  address beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_addr`  out  WIDTH  current address.
- `out_pass_end`  out  1  this beat is the last of its pass.
- `out_last`  out  1  this beat is the last of the job.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  2  valid while `done`=1: 00 complete, 01 bad config, 10 aborted.

## Operation
- States: IDLE, RUN. `cfg_ready`=1 only in IDLE. `busy`=1 only in RUN. `out_valid`=1 in every RUN cycle.
- Descriptor acceptance: a descriptor is accepted on `cfg_valid & cfg_ready`. All cfg fields are latched on acceptance; later changes on the cfg inputs have no effect on the running job.
- Bad config: `cfg_step`==0, `cfg_min`>`cfg_max`, or `cfg_passes`==0.
  - The block stays in IDLE and pulses `done` with `status`=01 the next cycle.
  - No beats are emitted.
- Good config: go to RUN with addr=min, direction up, pass counter=0.
- Next-address arithmetic runs in WIDTH+1 bits so there is no overflow alias. This holds even when max=2^WIDTH-1.
  - Up: nxt=addr+step. The pass ends if nxt>max.
  - Down: nxt=addr-step, signed WIDTH+2 bits. The pass ends if nxt<min.
- `out_pass_end` is combinational from the current addr, direction and latched config.
- `out_last` = `out_pass_end` & (pass counter == passes-1).
- On each beat handshake (`out_valid & out_ready`):
  - If the pass has not ended, addr=nxt.
  - If the pass ended and the beat was not last: increment the pass counter. If bounce, flip direction and load addr=max (now down) or addr=min (now up). Otherwise load addr=min.
  - If the beat was last: go to IDLE and pulse `done` with `status`=00 the next cycle.
- Stall: with `out_ready`=0, `out_addr`, `out_pass_end` and `out_last` hold stable and `out_valid` stays high.
- Abort: `abort`=1 in RUN goes to IDLE next cycle and pulses `done` with `status`=10.
  - Exception: if the final beat handshakes in the same cycle, completion wins (`status`=00).
  - A non-final beat that handshakes in the abort cycle counts as transferred.
- `abort` in IDLE is ignored. A `done` pulse is never produced without a preceding acceptance.
- Reset: `rst` in any state forces IDLE immediately at the next edge and discards the job. No `done` pulse is produced.

## Timing
- Reset values: state IDLE, so `cfg_ready`=1. `out_valid`, `busy`, `done`, `out_pass_end` and `out_last` are 0. `status`=00. `out_addr`=0.
- Config latency: acceptance in cycle N gives `out_valid`=1 with addr=min in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1.
- Completion: the final handshake in cycle N gives `done` and `cfg_ready` in cycle N+1. A new descriptor may be accepted in N+1, giving its first beat in N+2.
- Bad config and abort: `done` arrives one cycle after the triggering edge.

## Test plan
- Plain passes: min=2, max=9, step=3, passes=2, bounce=0, `out_ready`=1.
  - Required: beats 2,5,8,2,5,8. `out_pass_end` on both 8s, `out_last` on the second 8 only.
  - Required: `done`/`status`=00 one cycle after the last beat, 7 cycles after acceptance.
- Bounce: same config with bounce=1.
  - Required: beats 2,5,8,9,6,3. `out_pass_end` on 8 and 3, `out_last` on 3.
- Top of range: WIDTH=8, min=250, max=255, step=5, passes=1.
  - Required: beats 250,255, then `done`. No wrap to small values.
- Backpressure: randomly toggle `out_ready` during the plain-passes job.
  - Required: the address sequence is unchanged and outputs hold stable while stalled.
- Bad config: step=0, then separately min=9/max=2, then separately passes=0.
  - Required: each gives `done` with `status`=01 one cycle after acceptance and zero beats.
- Abort and reset: abort on the 3rd beat of a long job, then abort coincident with a final-beat handshake, then assert `rst` mid-job.
  - Required: abort mid-job gives `status`=10. The coincident case gives `status`=00. Reset returns to IDLE with no `done` pulse.

Source files
------------

// File: rtl/stv_stride_sequencer.sv
// Strided address sequencer: walks [min,max] by step over one or more passes,
// optionally bouncing direction between passes, with a done/status pulse at the end.
module stv_stride_sequencer #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_min,
  input  logic [WIDTH-1:0]  cfg_max,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              cfg_bounce,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_addr,
  output logic              out_pass_end,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  step;
    logic [PASS_W-1:0] passes;
    logic              bounce;
  } cfg_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BAD   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic              down_q, down_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;

  // Widened arithmetic so stepping past the top or below zero never aliases.
  logic        [WIDTH:0]   up_nxt;
  logic signed [WIDTH+1:0] dn_nxt;
  logic                    pass_end_raw, is_run, beat, cfg_bad;

  always_comb begin
    up_nxt       = {1'b0, addr_q} + {1'b0, cfg_q.step};
    dn_nxt       = $signed({2'b00, addr_q}) - $signed({2'b00, cfg_q.step});
    pass_end_raw = down_q ? (dn_nxt < $signed({2'b00, cfg_q.lo}))
                          : (up_nxt > {1'b0, cfg_q.hi});
    is_run       = (state_q == RUN);
    out_pass_end = is_run & pass_end_raw;
    out_last     = out_pass_end & (pass_q == PASS_W'(cfg_q.passes - 1'b1));
    beat         = is_run & out_ready;
    cfg_bad      = (cfg_step == '0) || (cfg_min > cfg_max) || (cfg_passes == '0);
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = is_run;
  assign out_valid = is_run;
  assign out_addr  = addr_q;
  assign done      = done_q;
  assign status    = status_q;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    down_d   = down_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            done_d   = 1'b1;
            status_d = ST_BAD;
          end else begin
            cfg_d   = '{lo: cfg_min, hi: cfg_max, step: cfg_step,
                        passes: cfg_passes, bounce: cfg_bounce};
            addr_d  = cfg_min;
            down_d  = 1'b0;
            pass_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          if (!pass_end_raw) begin
            addr_d = down_q ? dn_nxt[WIDTH-1:0] : up_nxt[WIDTH-1:0];
          end else if (out_last) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            status_d = ST_OK;
          end else begin
            pass_d = pass_q + 1'b1;
            if (cfg_q.bounce) begin
              down_d = ~down_q;
              addr_d = down_q ? cfg_q.lo : cfg_q.hi;
            end else begin
              addr_d = cfg_q.lo;
            end
          end
        end
        // A final beat completing in the abort cycle reports completion instead.
        if (abort && !(beat && out_last)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          status_d = ST_ABORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      addr_q   <= '0;
      down_q   <= 1'b0;
      pass_q   <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      down_q   <= down_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_stv_stride_sequencer.sv
// Directed bench for stv_stride_sequencer: passes, bounce, top of range,
// backpressure, bad config, abort and reset.
module tb_stv_stride_sequencer;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_ready, cfg_bounce, abort;
  logic [7:0] cfg_min, cfg_max, cfg_step, cfg_passes;
  logic       out_valid, out_ready, out_pass_end, out_last, busy, done;
  logic [7:0] out_addr;
  logic [1:0] status;

  int nvec = 0;
  int nerr = 0;

  int q_addr[$];
  bit q_pe[$];
  bit q_last[$];
  int done_at;
  int stat_got;
  int stall_bad;

  always #5 clk = ~clk;

  stv_stride_sequencer #(.WIDTH(8), .PASS_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step),
    .cfg_passes(cfg_passes), .cfg_bounce(cfg_bounce), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_pass_end(out_pass_end), .out_last(out_last), .busy(busy),
    .done(done), .status(status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int mn, input int mx, input int st, input int ps, input bit b);
    cfg_min = 8'(mn); cfg_max = 8'(mx); cfg_step = 8'(st);
    cfg_passes = 8'(ps); cfg_bounce = b; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_min = 8'hAA; cfg_max = 8'h00; cfg_step = 8'h00; cfg_passes = 8'h00;
  endtask

  // Records handshaked beats until done (left pending at the done cycle).
  task automatic collect(input int budget, input bit rnd);
    bit         prev_stall = 1'b0;
    logic [7:0] pa;
    logic       ppe, pl;
    q_addr.delete(); q_pe.delete(); q_last.delete();
    done_at = -1; stat_got = -1; stall_bad = 0;
    pa = '0; ppe = 1'b0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        done_at = c; stat_got = int'(status);
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!out_valid || out_addr !== pa || out_pass_end !== ppe || out_last !== pl))
        stall_bad++;
      if (out_valid && out_ready) begin
        q_addr.push_back(int'(out_addr)); q_pe.push_back(out_pass_end); q_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      pa = out_addr; ppe = out_pass_end; pl = out_last;
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    nvec++;
    if ({cfg_ready, out_valid, busy, done, out_pass_end, out_last, status, out_addr} !== {6'b100000, 2'b00, 8'h00}) begin
      nerr++; $display("FAIL reset_state got %b", {cfg_ready, out_valid, busy, done, out_pass_end, out_last, status, out_addr});
    end
  endtask

  task automatic test_plain(input bit rnd);
    int ea[6] = '{2, 5, 8, 2, 5, 8};
    bit ep[6] = '{0, 0, 1, 0, 0, 1};
    bit el[6] = '{0, 0, 0, 0, 0, 1};
    accept(2, 9, 3, 2, 1'b0);
    collect(200, rnd);
    nvec++;
    if (q_addr.size() != 6) begin nerr++; $display("FAIL plain_count rnd=%0d got %0d want 6", rnd, q_addr.size()); end
    for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
      nvec++;
      if (q_addr[i] != ea[i] || q_pe[i] != ep[i] || q_last[i] != el[i]) begin
        nerr++; $display("FAIL plain_beat%0d rnd=%0d got a=%0d pe=%0d l=%0d want a=%0d pe=%0d l=%0d",
                         i, rnd, q_addr[i], q_pe[i], q_last[i], ea[i], ep[i], el[i]);
      end
    end
    nvec++;
    if (stat_got != 0 || (!rnd && done_at != 6) || (rnd && done_at < 6)) begin
      nerr++; $display("FAIL plain_done rnd=%0d got at=%0d st=%0d want at=6 st=0", rnd, done_at, stat_got);
    end
    if (rnd) begin
      nvec++;
      if (stall_bad != 0) begin nerr++; $display("FAIL stall_hold got %0d changes want 0", stall_bad); end
    end
  endtask

  task automatic test_back_to_back();
    nvec++;
    if (cfg_ready !== 1'b1 || done !== 1'b1) begin
      nerr++; $display("FAIL b2b_ready got rdy=%b done=%b want 1 1", cfg_ready, done);
    end
    accept(7, 7, 1, 1, 1'b0);
    nvec++;
    if (out_valid !== 1'b1 || out_addr !== 8'd7 || out_last !== 1'b1) begin
      nerr++; $display("FAIL b2b_first got v=%b a=%0d l=%b want 1 7 1", out_valid, out_addr, out_last);
    end
    collect(20, 1'b0);
    nvec++;
    if (done_at != 1 || stat_got != 0) begin
      nerr++; $display("FAIL b2b_done got at=%0d st=%0d want 1 0", done_at, stat_got);
    end
  endtask

  task automatic test_bounce();
    int ea[6] = '{2, 5, 8, 9, 6, 3};
    bit ep[6] = '{0, 0, 1, 0, 0, 1};
    accept(2, 9, 3, 2, 1'b1);
    collect(50, 1'b0);
    nvec++;
    if (q_addr.size() != 6 || done_at != 6 || stat_got != 0) begin
      nerr++; $display("FAIL bounce_len got n=%0d at=%0d st=%0d want 6 6 0", q_addr.size(), done_at, stat_got);
    end
    for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
      nvec++;
      if (q_addr[i] != ea[i] || q_pe[i] != ep[i] || q_last[i] != (i == 5)) begin
        nerr++; $display("FAIL bounce_beat%0d got a=%0d pe=%0d l=%0d want a=%0d pe=%0d l=%0d",
                         i, q_addr[i], q_pe[i], q_last[i], ea[i], ep[i], (i == 5));
      end
    end
  endtask

  task automatic test_top();
    accept(250, 255, 5, 1, 1'b0);
    collect(50, 1'b0);
    nvec++;
    if (q_addr.size() != 2 || done_at != 2 || stat_got != 0) begin
      nerr++; $display("FAIL top_len got n=%0d at=%0d st=%0d want 2 2 0", q_addr.size(), done_at, stat_got);
    end else if (q_addr[0] != 250 || q_addr[1] != 255 || q_last[1] != 1'b1 || q_pe[0] != 1'b0) begin
      nerr++; $display("FAIL top_beats got %0d,%0d l=%0d want 250,255 l=1", q_addr[0], q_addr[1], q_last[1]);
    end
  endtask

  task automatic test_bad_cfg();
    int bm[3] = '{0, 9, 0};
    int bx[3] = '{9, 2, 9};
    int bs[3] = '{0, 1, 1};
    int bp[3] = '{1, 1, 0};
    for (int k = 0; k < 3; k++) begin
      accept(bm[k], bx[k], bs[k], bp[k], 1'b0);
      collect(10, 1'b0);
      nvec++;
      if (done_at != 0 || stat_got != 1 || q_addr.size() != 0 || cfg_ready !== 1'b1) begin
        nerr++; $display("FAIL bad_cfg%0d got at=%0d st=%0d n=%0d want 0 1 0", k, done_at, stat_got, q_addr.size());
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int  n = 0;
    bit  seen = 1'b0;
    // Abort on the third beat of a long job; that beat still transfers.
    accept(0, 200, 1, 3, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) n++;
      abort = (c == 2);
      tick();
    end
    abort = 1'b0;
    nvec++;
    if (n != 3 || done !== 1'b1 || status !== 2'b10 || busy !== 1'b0) begin
      nerr++; $display("FAIL abort_mid got n=%0d done=%b st=%b busy=%b want 3 1 10 0", n, done, status, busy);
    end
    tick();
    // Abort coincident with the final beat: completion wins.
    accept(0, 4, 2, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      abort = (c == 2);
      if (c == 2 && (out_addr !== 8'd4 || out_last !== 1'b1)) begin
        nvec++; nerr++; $display("FAIL abort_final_beat got a=%0d l=%b want 4 1", out_addr, out_last);
      end
      tick();
    end
    abort = 1'b0;
    nvec++;
    if (done !== 1'b1 || status !== 2'b00) begin
      nerr++; $display("FAIL abort_coincident got done=%b st=%b want 1 00", done, status);
    end
    tick();
    // Abort while idle is ignored.
    abort = 1'b1;
    for (int c = 0; c < 4; c++) begin tick(); if (done) seen = 1'b1; end
    abort = 1'b0;
    nvec++;
    if (seen) begin nerr++; $display("FAIL abort_idle got done=1 want 0"); end
  endtask

  task automatic test_rst_mid();
    bit seen = 1'b0;
    accept(0, 100, 1, 2, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL rst_mid got rdy=%b busy=%b v=%b done=%b want 1 0 0 0", cfg_ready, busy, out_valid, done);
    end
    for (int c = 0; c < 5; c++) begin if (done) seen = 1'b1; tick(); end
    nvec++;
    if (seen) begin nerr++; $display("FAIL rst_no_done got done pulse want none"); end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_min = '0; cfg_max = '0; cfg_step = '0; cfg_passes = '0; cfg_bounce = 1'b0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_plain(1'b0);
    test_back_to_back();
    tick();
    test_bounce();
    tick();
    test_top();
    tick();
    test_plain(1'b1);
    tick();
    test_bad_cfg();
    test_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
